// File: rtl/seq_sort_engine_if.sv
// seq_sort_engine_if: start/done handshake and data bus for the sequential sorter
interface seq_sort_engine_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   logic                     start;
   logic                     descend;
   logic [WIDTH*DEPTH-1:0]   in_data;
   logic                     busy;
   logic                     done;
   logic                     out_valid;
   logic [WIDTH*DEPTH-1:0]   out_data;

   modport master (output start, descend, in_data, input busy, done, out_valid, out_data);
   modport slave  (input start, descend, in_data, output busy, done, out_valid, out_data);
endinterface

// File: rtl/seq_sort_engine.sv
// seq_sort_engine: odd-even transposition sorter, one compare-exchange pass per clock
module seq_sort_engine #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_sort_engine_if.slave   bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int N  = WIDTH * DEPTH;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SORT = 1'b1;

   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_desc;
   logic [N-1:0]  r_work;
   logic [N-1:0]  r_out;
   logic          r_busy;
   logic          r_done;
   logic          r_valid;
   logic [N-1:0]  w_pass;
   logic          w_last;

   assign w_last        = r_cnt == CW'(DEPTH - 1);
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_out;

   // one pass: pairs starting at even lanes when r_cnt is even, odd lanes when odd; an unpaired end lane passes through
   always_comb begin
      w_pass = r_work;
      for (int k = 0; k < DEPTH - 1; k++) begin
         if (k[0] == r_cnt[0] &&
             (r_desc ? r_work[k*WIDTH +: WIDTH] < r_work[(k+1)*WIDTH +: WIDTH]
                     : r_work[k*WIDTH +: WIDTH] > r_work[(k+1)*WIDTH +: WIDTH])) begin
            w_pass[k*WIDTH +: WIDTH]     = r_work[(k+1)*WIDTH +: WIDTH];
            w_pass[(k+1)*WIDTH +: WIDTH] = r_work[k*WIDTH +: WIDTH];
         end
      end
   end

   // job control: accept in IDLE, run DEPTH passes, publish result on the last pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_desc  <= 1'b0;
         r_work  <= '0;
         r_out   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (bus.start) begin
               r_work  <= bus.in_data;
               r_desc  <= bus.descend;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
               r_valid <= 1'b0;
               r_state <= S_SORT;
            end
         end else begin
            r_work <= w_pass;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
               r_out   <= w_pass;
               r_done  <= 1'b1;
               r_valid <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_sort_engine.sv
// tb_seq_sort_engine: directed and random sort jobs checked against a queue-sort model
module tb_seq_sort_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_sort_engine_if #(.WIDTH(4), .DEPTH(4)) ia ();
   seq_sort_engine_if #(.WIDTH(8), .DEPTH(5)) ib ();

   seq_sort_engine #(.WIDTH(4), .DEPTH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
   seq_sort_engine #(.WIDTH(8), .DEPTH(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

   // reference: unpack lanes, sort with the language's queue sort, repack lane 0 first
   function automatic logic [63:0] model(input logic [63:0] d, input logic dsc, input int w, input int n);
      int q[$];
      logic [63:0] r = '0;
      logic [63:0] m = (64'd1 << w) - 64'd1;
      for (int i = 0; i < n; i++) q.push_back(int'((d >> (i*w)) & m));
      if (dsc) q.rsort(); else q.sort();
      for (int i = 0; i < n; i++) r |= 64'(q[i]) << (i*w);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit b, input logic s, input logic dsc, input logic [63:0] d);
      if (b) begin
         ib.start = s; ib.descend = dsc; ib.in_data = d[39:0];
      end else begin
         ia.start = s; ia.descend = dsc; ia.in_data = d[15:0];
      end
   endtask

   function automatic logic done_of(input bit b);
      return b ? ib.done : ia.done;
   endfunction

   function automatic logic busy_of(input bit b);
      return b ? ib.busy : ia.busy;
   endfunction

   function automatic logic valid_of(input bit b);
      return b ? ib.out_valid : ia.out_valid;
   endfunction

   function automatic logic [63:0] out_of(input bit b);
      return b ? 64'(ib.out_data) : 64'(ia.out_data);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // one full job: accept, scramble inputs mid-job, wait bounded for done, check result and latency
   task automatic job(input bit b, input logic [63:0] d, input logic dsc, input string tag);
      int n_l = b ? 5 : 4;
      logic [63:0] e = model(d, dsc, b ? 8 : 4, n_l);
      int n = 0;
      drive(b, 1'b1, dsc, d);
      cyc();
      drive(b, 1'b0, 1'($urandom), {$urandom, $urandom});
      chk({tag, " busy"}, 64'(busy_of(b)), 64'd1);
      chk({tag, " valid_drop"}, 64'(valid_of(b)), 64'd0);
      while (done_of(b) !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(n_l));
      chk({tag, " data"}, out_of(b), e);
      chk({tag, " valid"}, 64'(valid_of(b)), 64'd1);
      chk({tag, " idle"}, 64'(busy_of(b)), 64'd0);
      cyc();
      chk({tag, " pulse"}, 64'(done_of(b)), 64'd0);
   endtask

   initial begin
      logic [63:0] e1;
      logic [63:0] e2;
      int          nd;
      drive(1'b0, 1'b0, 1'b0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 64'd0);
      #12;
      chk("reset busy", 64'(ia.busy), 64'd0);
      chk("reset done", 64'(ia.done), 64'd0);
      chk("reset valid", 64'(ia.out_valid), 64'd0);
      chk("reset data", 64'(ia.out_data), 64'd0);
      rst_n = 1'b1;
      cyc();

      job(1'b0, 64'h3142, 1'b0, "asc3142");
      chk("asc3142 const", 64'(ia.out_data), 64'h4321);
      job(1'b0, 64'h3142, 1'b1, "desc3142");
      chk("desc3142 const", 64'(ia.out_data), 64'h1234);
      job(1'b0, 64'h5A5A, 1'b0, "dups");
      chk("dups const", 64'(ia.out_data), 64'hAA55);
      job(1'b0, 64'hFA50, 1'b0, "sorted");
      chk("sorted const", 64'(ia.out_data), 64'hFA50);

      e1 = model(64'h3142, 1'b0, 4, 4);
      e2 = model(64'h8E07, 1'b0, 4, 4);
      drive(1'b0, 1'b1, 1'b0, 64'h3142);
      cyc();
      for (int i = 1; i <= 9; i++) begin
         if (i == 1) ia.in_data = 16'h8E07;
         cyc();
         if (i == 5) ia.start = 1'b0;
         chk($sformatf("held done@%0d", i), 64'(ia.done), 64'((i == 4) || (i == 9)));
         if (i == 4) chk("held first", 64'(ia.out_data), e1);
         if (i == 5) chk("held reaccept", 64'(ia.busy), 64'd1);
         if (i == 5) chk("held keep", 64'(ia.out_data), e1);
         if (i == 9) chk("held second", 64'(ia.out_data), e2);
      end
      cyc();

      drive(1'b0, 1'b1, 1'b1, 64'h9C3D);
      cyc();
      ia.start = 1'b0;
      cyc();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst busy", 64'(ia.busy), 64'd0);
      chk("arst done", 64'(ia.done), 64'd0);
      chk("arst valid", 64'(ia.out_valid), 64'd0);
      chk("arst data", 64'(ia.out_data), 64'd0);
      #1 rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (ia.done === 1'b1) nd++;
      end
      chk("arst no done", 64'(nd), 64'd0);
      job(1'b0, 64'h9C3D, 1'b1, "after_rst");

      job(1'b1, 64'h017F8000FF, 1'b0, "w8d5");
      chk("w8d5 const", 64'(ib.out_data), 64'h00FF807F0100);
      job(1'b1, 64'h017F8000FF, 1'b1, "w8d5 desc");

      for (int i = 0; i < 16; i++)
         job(1'b0, 64'($urandom_range(0, 65535)), 1'($urandom), $sformatf("rndA%0d", i));
      for (int i = 0; i < 6; i++)
         job(1'b1, {$urandom, $urandom}, 1'($urandom), $sformatf("rndB%0d", i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
